fft_r2_stage_seq: RTL and testbench



---
 rtl/fft_pkg.sv | 52 +++++
 rtl/fft_r2_stage_seq_if.sv | 41 ++++
 rtl/fft_bfly_addsub.sv | 38 +++
 rtl/fft_r2_stage_seq.sv | 168 ++++++++++++++++
 tb/tb_fft_r2_stage_seq.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT stage sequencers.
//   state_t       : sequencer FSM encoding
//   bfly_idx_t    : operand addresses and twiddle index of one butterfly
//   bfly_index()  : addrA / addrB / fi for butterfly k of stage s
//   sat_to()      : clamp a 33-bit signed value to a w-bit signed range
//   round_shift() : (v + rnd) >>> 1
package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_A, ST_RD_B, ST_ISSUE, ST_WAIT, ST_WR_TOP, ST_WR_BOT, ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic [7:0] fi;
  } bfly_idx_t;

  // span = 2^s; A sits at grp*2*span + pos, B one span above it.
  // When s is out of range the fi shift amount wraps large and fi reads 0.
  function automatic bfly_idx_t bfly_index(input logic [7:0] k, input logic [3:0] s,
                                           input logic [3:0] log2n);
    bfly_idx_t  r;
    logic [7:0] span, pos, grp;
    span     = 8'd1 << s;
    pos      = k & (span - 8'd1);
    grp      = k >> s;
    r.addr_a = (grp << (s + 4'd1)) | pos;
    r.addr_b = r.addr_a + span;
    r.fi     = pos << (log2n - 4'd1 - s);
    return r;
  endfunction

  function automatic logic signed [31:0] sat_to(input logic signed [32:0] v,
                                                input int unsigned w);
    logic signed [32:0] hi, lo;
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (v > hi) return hi[31:0];
    else if (v < lo) return lo[31:0];
    else return v[31:0];
  endfunction

  function automatic logic signed [31:0] round_shift(input logic signed [32:0] v,
                                                     input logic rnd);
    logic signed [32:0] t;
    t = v + $signed({32'd0, rnd});
    t = t >>> 1;
    return t[31:0];
  endfunction

endpackage

// File: rtl/fft_r2_stage_seq_if.sv
// Bus bundle between the stage sequencer and its environment (start/status,
// working-memory read/write ports, twiddle multiplier request/response).
//   master : the sequencer (drives o_*, samples i_*)
//   slave  : memory / multiplier / controller side
interface fft_r2_stage_seq_if #(
  parameter int SIZE_DATA_FI  = 3,
  parameter int DATA_FFT_SIZE = 16
);
  logic                            i_start;
  logic [3:0]                      i_stage;
  logic                            o_busy;
  logic                            o_done;
  logic                            o_error;
  logic                            o_rd_en;
  logic [SIZE_DATA_FI-1:0]         o_rd_addr;
  logic signed [DATA_FFT_SIZE-1:0] i_rd_data_i;
  logic signed [DATA_FFT_SIZE-1:0] i_rd_data_q;
  logic                            o_wr_en;
  logic [SIZE_DATA_FI-1:0]         o_wr_addr;
  logic signed [DATA_FFT_SIZE-1:0] o_wr_data_i;
  logic signed [DATA_FFT_SIZE-1:0] o_wr_data_q;
  logic                            o_mul_en;
  logic signed [DATA_FFT_SIZE-1:0] o_mul_data_i;
  logic signed [DATA_FFT_SIZE-1:0] o_mul_data_q;
  logic [15:0]                     o_mul_fi_deg;
  logic signed [DATA_FFT_SIZE-1:0] i_mul_res_i;
  logic signed [DATA_FFT_SIZE-1:0] i_mul_res_q;
  logic                            i_mul_valid;

  modport master (
    input  i_start, i_stage, i_rd_data_i, i_rd_data_q, i_mul_res_i, i_mul_res_q, i_mul_valid,
    output o_busy, o_done, o_error, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr,
           o_wr_data_i, o_wr_data_q, o_mul_en, o_mul_data_i, o_mul_data_q, o_mul_fi_deg
  );

  modport slave (
    output i_start, i_stage, i_rd_data_i, i_rd_data_q, i_mul_res_i, i_mul_res_q, i_mul_valid,
    input  o_busy, o_done, o_error, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr,
           o_wr_data_i, o_wr_data_q, o_mul_en, o_mul_data_i, o_mul_data_q, o_mul_fi_deg
  );
endinterface

// File: rtl/fft_bfly_addsub.sv
// Butterfly combine for one component: top = A + P, bot = A - P, formed at
// W+1 bits, then either halved (optional round-half-up) or saturated to W bits.
//   a, p     : in  W-bit signed operands (A and the twiddled product)
//   top, bot : out W-bit signed results
module fft_bfly_addsub
  import fft_pkg::*;
#(
  parameter int W         = 16,
  parameter int SCALE     = 1,
  parameter int USE_ROUND = 1
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] p,
  output logic signed [W-1:0] top,
  output logic signed [W-1:0] bot
);
  logic signed [W:0]  sum, dif;
  logic signed [32:0] sum_x, dif_x;
  logic signed [31:0] top_x, bot_x;

  assign sum   = $signed({a[W-1], a}) + $signed({p[W-1], p});
  assign dif   = $signed({a[W-1], a}) - $signed({p[W-1], p});
  assign sum_x = {{(32-W){sum[W]}}, sum};
  assign dif_x = {{(32-W){dif[W]}}, dif};

  always_comb begin
    if (SCALE != 0) begin
      top_x = round_shift(sum_x, USE_ROUND != 0);
      bot_x = round_shift(dif_x, USE_ROUND != 0);
    end else begin
      top_x = sat_to(sum_x, W);
      bot_x = sat_to(dif_x, W);
    end
  end

  assign top = top_x[W-1:0];
  assign bot = bot_x[W-1:0];
endmodule

// File: rtl/fft_r2_stage_seq.sv
// Sequencer for one radix-2 DIT FFT stage. For each butterfly k it reads A and
// B from the working memory, hands B and the twiddle index to the multiplier,
// waits for W*B, and writes A+W*B / A-W*B back in place.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (master) : start/stage in, busy/done/error out, memory rd/wr ports,
//                  multiplier request (en/data/fi_deg) and response (res/valid)
//
// state     | meaning
// IDLE      | waiting for i_start
// RD_A      | read strobe for operand A
// RD_B      | read strobe for operand B, capture A
// ISSUE     | one-cycle multiplier request with B (straight off the read bus)
// WAIT      | waiting for product, bounded by MULT_TIMEOUT
// WR_TOP    | write A + W*B at addrA
// WR_BOT    | write A - W*B at addrB, advance k or finish
// DONE      | one-cycle done pulse
module fft_r2_stage_seq
  import fft_pkg::*;
#(
  parameter int SIZE_DATA_FI  = 3,
  parameter int DATA_FFT_SIZE = 16,
  parameter int SCALE         = 1,
  parameter int USE_ROUND     = 1,
  parameter int MULT_TIMEOUT  = 64
) (
  input logic i_clk,
  input logic i_rst,
  fft_r2_stage_seq_if.master bus
);
  localparam int KW = SIZE_DATA_FI - 1;
  localparam int TW = $clog2(MULT_TIMEOUT + 1);
  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(MULT_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  state_t                          state;
  logic [KW-1:0]                   k;
  logic [3:0]                      stage_r;
  logic [TW-1:0]                   tcnt;
  logic                            error_r;
  logic signed [DATA_FFT_SIZE-1:0] a_i, a_q, p_i, p_q;
  logic signed [DATA_FFT_SIZE-1:0] top_i, top_q, bot_i, bot_q;
  bfly_idx_t                       idx;

  assign idx = bfly_index(8'(k), stage_r, 4'(SIZE_DATA_FI));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      stage_r <= '0;
      tcnt    <= '0;
      error_r <= 1'b0;
      a_i     <= '0;
      a_q     <= '0;
      p_i     <= '0;
      p_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.i_start) begin
          stage_r <= bus.i_stage;
          k       <= '0;
          error_r <= 1'b0;
          if (bus.i_stage >= 4'(SIZE_DATA_FI)) begin
            error_r <= 1'b1;
            state   <= ST_DONE;
          end else begin
            state   <= ST_RD_A;
          end
        end
        ST_RD_A: state <= ST_RD_B;
        ST_RD_B: begin
          a_i   <= bus.i_rd_data_i;
          a_q   <= bus.i_rd_data_q;
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          tcnt  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A product arriving on the last allowed cycle still counts.
          if (bus.i_mul_valid) begin
            p_i   <= bus.i_mul_res_i;
            p_q   <= bus.i_mul_res_q;
            state <= ST_WR_TOP;
          end else if (tcnt == T_LAST) begin
            error_r <= 1'b1;
            state   <= ST_DONE;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end
        ST_WR_TOP: state <= ST_WR_BOT;
        ST_WR_BOT: begin
          if (k == K_LAST) begin
            state <= ST_DONE;
          end else begin
            k     <= k + K_ONE;
            state <= ST_RD_A;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  fft_bfly_addsub #(.W(DATA_FFT_SIZE), .SCALE(SCALE), .USE_ROUND(USE_ROUND)) u_bfly_i (
    .a(a_i), .p(p_i), .top(top_i), .bot(bot_i)
  );
  fft_bfly_addsub #(.W(DATA_FFT_SIZE), .SCALE(SCALE), .USE_ROUND(USE_ROUND)) u_bfly_q (
    .a(a_q), .p(p_q), .top(top_q), .bot(bot_q)
  );

  // Outputs decode the registered state; the reset cycle forces them all low
  // so a reset landing on a write state cannot leak a strobe.
  always_comb begin
    bus.o_busy       = 1'b0;
    bus.o_done       = 1'b0;
    bus.o_error      = 1'b0;
    bus.o_rd_en      = 1'b0;
    bus.o_rd_addr    = '0;
    bus.o_wr_en      = 1'b0;
    bus.o_wr_addr    = '0;
    bus.o_wr_data_i  = '0;
    bus.o_wr_data_q  = '0;
    bus.o_mul_en     = 1'b0;
    bus.o_mul_data_i = '0;
    bus.o_mul_data_q = '0;
    bus.o_mul_fi_deg = '0;
    if (!i_rst) begin
      bus.o_busy  = (state != ST_IDLE);
      bus.o_error = error_r;
      case (state)
        ST_RD_A: begin
          bus.o_rd_en   = 1'b1;
          bus.o_rd_addr = idx.addr_a[SIZE_DATA_FI-1:0];
        end
        ST_RD_B: begin
          bus.o_rd_en   = 1'b1;
          bus.o_rd_addr = idx.addr_b[SIZE_DATA_FI-1:0];
        end
        ST_ISSUE: begin
          bus.o_mul_en     = 1'b1;
          bus.o_mul_data_i = bus.i_rd_data_i;
          bus.o_mul_data_q = bus.i_rd_data_q;
          bus.o_mul_fi_deg = {8'd0, idx.fi};
        end
        ST_WR_TOP: begin
          bus.o_wr_en     = 1'b1;
          bus.o_wr_addr   = idx.addr_a[SIZE_DATA_FI-1:0];
          bus.o_wr_data_i = top_i;
          bus.o_wr_data_q = top_q;
        end
        ST_WR_BOT: begin
          bus.o_wr_en     = 1'b1;
          bus.o_wr_addr   = idx.addr_b[SIZE_DATA_FI-1:0];
          bus.o_wr_data_i = bot_i;
          bus.o_wr_data_q = bot_q;
        end
        ST_DONE: bus.o_done = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_r2_stage_seq.sv
// Scoreboard bench: three sequencers (SCALE=0; SCALE=1 rounding; SCALE=1
// truncating), each with its own memory and a P = B multiplier model. Tests
// push expected writes / twiddle indices; one monitor pops and compares.
module tb_fft_r2_stage_seq;
  typedef struct {
    int addr;
    int di;
    int dq;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  wr_t exp_wr[$];
  int  exp_fi[$];

  logic start_v [3];
  logic [3:0] stage_v [3];
  logic mul_dead;
  logic ld_en;
  logic signed [15:0] ld_i [8];
  logic signed [15:0] ld_q [8];
  int sel;

  logic               wr_en_a  [3];
  logic [2:0]         wr_addr_a[3];
  logic signed [15:0] wr_i_a   [3];
  logic signed [15:0] wr_q_a   [3];
  logic               mul_en_a [3];
  logic [15:0]        fi_a     [3];
  logic               rd_en_a  [3];
  logic               done_a   [3];
  logic               busy_a   [3];
  logic               error_a  [3];
  logic               any_out_a[3];

  for (genvar g = 0; g < 3; g++) begin : u
    fft_r2_stage_seq_if #(.SIZE_DATA_FI(3), .DATA_FFT_SIZE(16)) bus ();

    fft_r2_stage_seq #(
      .SIZE_DATA_FI(3), .DATA_FFT_SIZE(16),
      .SCALE(g == 0 ? 0 : 1), .USE_ROUND(g == 1 ? 1 : 0), .MULT_TIMEOUT(64)
    ) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
    );

    logic signed [15:0] mem_i [8];
    logic signed [15:0] mem_q [8];
    logic signed [15:0] rd_i = '0, rd_q = '0;
    logic signed [15:0] mb_i = '0, mb_q = '0;
    int mcnt = 0;

    always @(posedge clk) begin
      if (ld_en) begin
        for (int i = 0; i < 8; i++) begin
          mem_i[i] <= ld_i[i];
          mem_q[i] <= ld_q[i];
        end
      end else if (bus.o_wr_en) begin
        mem_i[bus.o_wr_addr] <= bus.o_wr_data_i;
        mem_q[bus.o_wr_addr] <= bus.o_wr_data_q;
      end
      if (bus.o_rd_en) begin
        rd_i <= mem_i[bus.o_rd_addr];
        rd_q <= mem_q[bus.o_rd_addr];
      end
      // Product presented in the fifth WAIT cycle: ten cycles per butterfly.
      if (bus.o_mul_en) begin
        mcnt <= 5;
        mb_i <= bus.o_mul_data_i;
        mb_q <= bus.o_mul_data_q;
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
      end
    end

    assign bus.i_start     = start_v[g];
    assign bus.i_stage     = stage_v[g];
    assign bus.i_rd_data_i = rd_i;
    assign bus.i_rd_data_q = rd_q;
    assign bus.i_mul_valid = (mcnt == 1) && !mul_dead;
    assign bus.i_mul_res_i = mb_i;
    assign bus.i_mul_res_q = mb_q;

    assign wr_en_a[g]   = bus.o_wr_en;
    assign wr_addr_a[g] = bus.o_wr_addr;
    assign wr_i_a[g]    = bus.o_wr_data_i;
    assign wr_q_a[g]    = bus.o_wr_data_q;
    assign mul_en_a[g]  = bus.o_mul_en;
    assign fi_a[g]      = bus.o_mul_fi_deg;
    assign rd_en_a[g]   = bus.o_rd_en;
    assign done_a[g]    = bus.o_done;
    assign busy_a[g]    = bus.o_busy;
    assign error_a[g]   = bus.o_error;
    assign any_out_a[g] = bus.o_busy | bus.o_done | bus.o_error | bus.o_rd_en |
                          (|bus.o_rd_addr) | bus.o_wr_en | (|bus.o_wr_addr) |
                          (|bus.o_wr_data_i) | (|bus.o_wr_data_q) | bus.o_mul_en |
                          (|bus.o_mul_data_i) | (|bus.o_mul_data_q) | (|bus.o_mul_fi_deg);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor state
  int done_cnt = 0, done_cyc = 0, issue_cyc = 0, mul_cnt = 0, rd_cnt = 0;
  int busy_acc = 0, busy_run = 0;

  always @(negedge clk) begin
    if (wr_en_a[sel]) begin
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected_addr", int'(wr_addr_a[sel]), -1);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        n_tests++;
        if (int'(wr_addr_a[sel]) != e.addr || int'(wr_i_a[sel]) != e.di ||
            int'(wr_q_a[sel]) != e.dq) begin
          n_fail++;
          $display("FAIL wr: got addr %0d data %0d/%0d, expected addr %0d data %0d/%0d",
                   wr_addr_a[sel], wr_i_a[sel], wr_q_a[sel], e.addr, e.di, e.dq);
        end
      end
    end
    if (mul_en_a[sel]) begin
      issue_cyc = cyc;
      mul_cnt++;
      if (exp_fi.size() == 0) chk("fi_unexpected", int'(fi_a[sel]), -1);
      else chk("mul_fi_deg", int'(fi_a[sel]), exp_fi.pop_front());
    end
    if (rd_en_a[sel]) rd_cnt++;
    if (done_a[sel]) begin
      done_cnt++;
      done_cyc = cyc;
      busy_run = busy_acc;
      busy_acc = 0;
    end else if (busy_a[sel]) begin
      busy_acc++;
    end
  end

  task automatic push_w(input int a, input int di, input int dq);
    wr_t e;
    e.addr = a; e.di = di; e.dq = dq;
    exp_wr.push_back(e);
  endtask

  task automatic load_mem(input int vi[8], input int vq[8]);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ld_i[i] = 16'(vi[i]);
      ld_q[i] = 16'(vq[i]);
    end
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic pulse_start(input int g, input int s);
    @(negedge clk);
    start_v[g] = 1'b1;
    stage_v[g] = 4'(s);
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) chk({nm, "_done_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic run_stage(input string nm, input int g, input int s, input int budget);
    int d0;
    sel = g;
    d0 = done_cnt;
    pulse_start(g, s);
    wait_done(nm, d0, budget);
  endtask

  initial begin
    int d0, r0, m0, n;
    rst = 1'b1;
    mul_dead = 1'b0;
    ld_en = 1'b0;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      stage_v[i] = 4'd0;
    end
    for (int i = 0; i < 8; i++) begin
      ld_i[i] = '0;
      ld_q[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("reset_outputs_u%0d", g), int'(any_out_a[g]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs_u0", int'(any_out_a[0]), 0);

    // s=0, SCALE=0: pairs (0,1) (2,3) (4,5) (6,7)
    load_mem('{10, 3, 20, 5, 0, 0, -7, 1}, '{0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 4; i++) exp_fi.push_back(0);
    push_w(0, 13, 0); push_w(1, 7, 0); push_w(2, 25, 0); push_w(3, 15, 0);
    push_w(4, 0, 0);  push_w(5, 0, 0); push_w(6, -6, 0); push_w(7, -8, 0);
    run_stage("s0", 0, 0, 200);
    chk("s0_busy_cycles", busy_run, 40);
    chk("s0_error", int'(error_a[0]), 0);

    // s=2 on the s=0 result: pairs (0,4) (1,5) (2,6) (3,7), fi 0,1,2,3
    for (int i = 0; i < 4; i++) exp_fi.push_back(i);
    push_w(0, 13, 0); push_w(4, 13, 0); push_w(1, 7, 0);  push_w(5, 7, 0);
    push_w(2, 19, 0); push_w(6, 31, 0); push_w(3, 7, 0);  push_w(7, 23, 0);
    run_stage("s2", 0, 2, 200);

    // s=1: pairs (0,2) (1,3) (4,6) (5,7), fi 0,2,0,2
    exp_fi.push_back(0); exp_fi.push_back(2); exp_fi.push_back(0); exp_fi.push_back(2);
    push_w(0, 32, 0); push_w(2, -6, 0);  push_w(1, 14, 0); push_w(3, 0, 0);
    push_w(4, 44, 0); push_w(6, -18, 0); push_w(5, 30, 0); push_w(7, -16, 0);
    run_stage("s1", 0, 1, 200);

    // Saturation at both rails
    load_mem('{32767, 1, 0, 0, 0, 0, 0, 0}, '{-32768, 1, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 4; i++) exp_fi.push_back(0);
    push_w(0, 32767, -32767); push_w(1, 32766, -32768);
    for (int i = 2; i < 8; i++) push_w(i, 0, 0);
    run_stage("sat", 0, 0, 200);

    // SCALE=1, round-half-up: (3+0+1)>>>1 = 2
    load_mem('{3, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 4; i++) exp_fi.push_back(0);
    push_w(0, 2, 0); push_w(1, 2, 0);
    for (int i = 2; i < 8; i++) push_w(i, 0, 0);
    run_stage("round", 1, 0, 200);

    // SCALE=1, truncate: 3>>>1 = 1
    load_mem('{3, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 4; i++) exp_fi.push_back(0);
    push_w(0, 1, 0); push_w(1, 1, 0);
    for (int i = 2; i < 8; i++) push_w(i, 0, 0);
    run_stage("trunc", 2, 0, 200);

    // Multiplier timeout: ISSUE, 64 WAIT cycles, then DONE
    mul_dead = 1'b1;
    exp_fi.push_back(0);
    run_stage("tmo", 0, 0, 300);
    chk("tmo_error", int'(error_a[0]), 1);
    chk("tmo_done_after_issue", done_cyc - issue_cyc, 65);
    mul_dead = 1'b0;

    // New start clears the sticky error
    load_mem('{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 4; i++) exp_fi.push_back(0);
    for (int i = 0; i < 8; i++) push_w(i, 0, 0);
    d0 = done_cnt;
    pulse_start(0, 0);
    chk("restart_clears_error", int'(error_a[0]), 0);
    wait_done("restart", d0, 200);
    chk("restart_error", int'(error_a[0]), 0);

    // Illegal stage: error and done, no memory traffic
    r0 = rd_cnt;
    run_stage("bad_stage", 0, 5, 10);
    chk("bad_stage_error", int'(error_a[0]), 1);
    chk("bad_stage_reads", rd_cnt - r0, 0);
    chk("bad_stage_busy", busy_run, 0);

    // Reset in WAIT of butterfly 2; a start while busy is ignored
    load_mem('{1, 2, 3, 4, 5, 6, 7, 8}, '{0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 3; i++) exp_fi.push_back(0);
    push_w(0, 3, 0); push_w(1, -1, 0); push_w(2, 7, 0); push_w(3, -1, 0);
    d0 = done_cnt;
    m0 = mul_cnt;
    pulse_start(0, 0);
    repeat (12) @(negedge clk);
    start_v[0] = 1'b1;
    stage_v[0] = 4'd2;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (mul_cnt < m0 + 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("rst_reached_bfly2", mul_cnt - m0, 3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_outputs", int'(any_out_a[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outputs", int'(any_out_a[0]), 0);
    repeat (10) @(negedge clk);
    chk("post_rst_no_done", done_cnt - d0, 0);
    chk("post_rst_busy", int'(busy_a[0]), 0);

    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("fi_queue_drained", exp_fi.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
